hv_alu_pipe: RTL and testbench

- Pipelined, handshaked successor to the combinational hypervector element-wise ALU.
- Adds circular-permutation and unary ops, a configurable register pipeline, valid/ready flow control with full-throughput backpressure, and a synchronous flush.
- Sits between the HV operand fetch (register file / item memory) and the associative memory / encoder datapath.

---
 rtl/hv_alu_pipe.sv | 120 ++++++++++++
 tb/tb_hv_alu_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_alu_pipe.sv
// hv_alu_pipe: pipelined, handshaked hypervector element-wise ALU.
//
// Computes one of eight bitwise/permutation ops on a full hypervector and
// moves the result through NumStages register stages with valid/ready flow
// control. The ready chain is combinational back from out_ready_i, so the
// pipe sustains one result per cycle and collapses bubbles under backpressure.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   clr_i                 synchronous flush of every stage valid flag
//   in_valid_i/in_ready_o input handshake (A_i, B_i, op_i, shift_i)
//   out_valid_o/out_ready_i output handshake (C_o)
//   busy_o                any stage holds valid data
//
// Opcodes: 0 xor, 1 and, 2 or, 3 rotate right, 4 rotate left, 5 not A,
//          6 pass A, 7 pass B, anything else xor.
module hv_alu_pipe #(
    parameter int HVDimension  = 512,
    parameter int NumOps       = 8,
    parameter int NumOpsWidth  = $clog2(NumOps),
    parameter int PermuteWidth = 5,
    parameter int NumStages    = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [HVDimension-1:0]  A_i,
    input  logic [HVDimension-1:0]  B_i,
    input  logic [NumOpsWidth-1:0]  op_i,
    input  logic [PermuteWidth-1:0] shift_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [HVDimension-1:0]  C_o,
    output logic                    busy_o
);

    localparam int LastStage = NumStages - 1;

    logic [NumStages-1:0]                  valid_q;
    logic [NumStages-1:0][HVDimension-1:0] data_q;
    logic [NumStages-1:0]                  ready;       // stage k may load this cycle
    logic [HVDimension-1:0]                alu_result;
    logic [HVDimension-1:0]                rot_right;
    logic [HVDimension-1:0]                rot_left;
    logic [31:0]                           rot_amt;
    logic [31:0]                           rot_amt_left;
    logic                                  all_full;

    // Rotations are taken from a doubled copy of A so the wrap-around is free.
    // A left rotate by s is the right rotate by (HVDimension - s) mod HVDimension.
    always_comb begin
        rot_amt      = 32'(shift_i) % 32'(HVDimension);
        rot_amt_left = (32'(HVDimension) - rot_amt) % 32'(HVDimension);
        rot_right    = HVDimension'({A_i, A_i} >> rot_amt);
        rot_left     = HVDimension'({A_i, A_i} >> rot_amt_left);
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves alu_result unassigned (no latch).
        alu_result = A_i ^ B_i;
        case (op_i)
            NumOpsWidth'(0): alu_result = A_i ^ B_i;
            NumOpsWidth'(1): alu_result = A_i & B_i;
            NumOpsWidth'(2): alu_result = A_i | B_i;
            NumOpsWidth'(3): alu_result = rot_right;
            NumOpsWidth'(4): alu_result = rot_left;
            NumOpsWidth'(5): alu_result = ~A_i;
            NumOpsWidth'(6): alu_result = A_i;
            NumOpsWidth'(7): alu_result = B_i;
            default:         alu_result = A_i ^ B_i;
        endcase
    end

    // Stage k can load iff the consumer is taking a result or some stage at or
    // after k is empty. Walking back from the output with an accumulator keeps
    // the chain free of self-referencing bits in `ready`.
    always_comb begin
        // NOTE: blocking assignments here, since all_full is a running value within this block.
        all_full = 1'b1;
        ready    = '0;
        for (int k = LastStage; k >= 0; k--) begin
            all_full = all_full & valid_q[k];
            ready[k] = out_ready_i || !all_full;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            // Flush only drops the valid flags; stale data is never observed.
            valid_q <= '0;
        end else begin
            if (ready[0]) begin
                valid_q[0] <= in_valid_i;
            end
            if (ready[0] && in_valid_i) begin
                data_q[0] <= alu_result;
            end
            for (int k = 1; k < NumStages; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= valid_q[k-1];
                end
                if (ready[k] && valid_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign in_ready_o  = ready[0] && !clr_i;
    assign out_valid_o = valid_q[LastStage];
    assign C_o         = data_q[LastStage];
    assign busy_o      = |valid_q;

endmodule

// File: tb/tb_hv_alu_pipe.sv
// Self-checking bench for hv_alu_pipe (default parameters).
// A queue of expected results, computed bit by bit from the opcode rules,
// follows every accepted input; outputs are sampled 1 ns after the falling edge.
module tb_hv_alu_pipe;

    localparam int H  = 512;
    localparam int NS = 2;
    localparam int OW = 3;
    localparam int PW = 5;

    typedef logic [H-1:0] hv_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clr_i;
    logic          in_valid_i;
    logic          in_ready_o;
    hv_t           A_i;
    hv_t           B_i;
    logic [OW-1:0] op_i;
    logic [PW-1:0] shift_i;
    logic          out_valid_o;
    logic          out_ready_i;
    hv_t           C_o;
    logic          busy_o;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pops   = 0;
    hv_t  exp_q[$];
    logic hold_pending = 1'b0;
    hv_t  held_c;
    logic last_acc, last_ov, last_busy, last_rdy;
    hv_t  last_c;

    hv_alu_pipe #(
        .HVDimension (H),
        .NumOps      (8),
        .NumOpsWidth (OW),
        .PermuteWidth(PW),
        .NumStages   (NS)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .A_i        (A_i),
        .B_i        (B_i),
        .op_i       (op_i),
        .shift_i    (shift_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .C_o        (C_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input hv_t obs, input hv_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each result bit derived independently from the opcode rules.
    function automatic hv_t ref_op(input hv_t a, input hv_t b, input int op, input int sh);
        hv_t c;
        int  s;
        s = sh % H;
        for (int i = 0; i < H; i++) begin
            case (op)
                1:       c[i] = a[i] & b[i];
                2:       c[i] = a[i] | b[i];
                3:       c[i] = a[(i + s) % H];
                4:       c[i] = a[(i - s + H) % H];
                5:       c[i] = ~a[i];
                6:       c[i] = a[i];
                7:       c[i] = b[i];
                default: c[i] = a[i] ^ b[i];
            endcase
        end
        return c;
    endfunction

    function automatic hv_t rand_hv();
        hv_t r;
        for (int w = 0; w < H / 32; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    // One clock cycle driven at the falling edge, checked against the model queue.
    task automatic step(input logic v, input hv_t a, input hv_t b, input int op,
                        input int sh, input logic ordy, input logic clr);
        @(negedge clk_i);
        in_valid_i  = v;
        A_i         = a;
        B_i         = b;
        op_i        = OW'(op);
        shift_i     = PW'(sh);
        out_ready_i = ordy;
        clr_i       = clr;
        #1;
        check("busy", hv_t'(busy_o), hv_t'(exp_q.size() != 0));
        if (exp_q.size() == 0) check("no_spurious_valid", hv_t'(out_valid_o), hv_t'(0));
        if (hold_pending) begin
            check("hold_valid", hv_t'(out_valid_o), hv_t'(1));
            check("hold_data", C_o, held_c);
        end
        if (clr) check("clr_blocks_input", hv_t'(in_ready_o), hv_t'(0));
        if (out_valid_o && ordy && exp_q.size() != 0) begin
            check("data", C_o, exp_q.pop_front());
            n_pops++;
        end
        hold_pending = out_valid_o && !ordy && !clr;
        held_c       = C_o;
        last_acc     = v && in_ready_o;
        last_ov      = out_valid_o;
        last_busy    = busy_o;
        last_rdy     = in_ready_o;
        last_c       = C_o;
        if (last_acc) exp_q.push_back(ref_op(a, b, op, sh));
        if (clr) exp_q.delete();
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) step(1'b0, '0, '0, 0, 0, 1'b1, 1'b0);
        check(tag, hv_t'(exp_q.size()), hv_t'(0));
    endtask

    // Single input into an empty pipe; result must appear exactly NS cycles later.
    task automatic send_expect(input string tag, input hv_t a, input int op, input int sh,
                               input hv_t exp);
        @(negedge clk_i);
        in_valid_i  = 1'b1;
        A_i         = a;
        B_i         = '0;
        op_i        = OW'(op);
        shift_i     = PW'(sh);
        out_ready_i = 1'b1;
        clr_i       = 1'b0;
        #1 check({tag, "_ready"}, hv_t'(in_ready_o), hv_t'(1));
        for (int c = 1; c < NS; c++) begin
            @(negedge clk_i);
            in_valid_i = 1'b0;
            #1 check({tag, "_latency"}, hv_t'(out_valid_o), hv_t'(0));
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        check({tag, "_valid"}, hv_t'(out_valid_o), hv_t'(1));
        check({tag, "_data"}, C_o, exp);
    endtask

    initial begin
        hv_t pa;
        hv_t pb;
        int  ops[6];
        hv_t expv[6];
        int  acc;
        int  sent;

        pa      = {64{8'hA5}};
        pb      = {64{8'h0F}};
        ops     = '{0, 1, 2, 5, 6, 7};
        expv    = '{{64{8'hAA}}, {64{8'h05}}, {64{8'hAF}}, {64{8'h5A}}, {64{8'hA5}}, {64{8'h0F}}};

        rst_ni      = 1'b0;
        clr_i       = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        A_i         = '0;
        B_i         = '0;
        op_i        = '0;
        shift_i     = '0;
        #2;
        check("rst_out_valid", hv_t'(out_valid_o), hv_t'(0));
        check("rst_c", C_o, hv_t'(0));
        check("rst_busy", hv_t'(busy_o), hv_t'(0));
        check("rst_in_ready", hv_t'(in_ready_o), hv_t'(1));
        #10 rst_ni = 1'b1;

        // Basic ops back to back, each result NS cycles after its input.
        for (int c = 0; c < 6 + NS; c++) begin
            @(negedge clk_i);
            in_valid_i  = (c < 6);
            A_i         = pa;
            B_i         = pb;
            op_i        = (c < 6) ? OW'(ops[c]) : '0;
            shift_i     = '0;
            out_ready_i = 1'b1;
            #1;
            if (c < 6) check("basic_ready", hv_t'(in_ready_o), hv_t'(1));
            if (c >= NS) begin
                check("basic_valid", hv_t'(out_valid_o), hv_t'(1));
                check($sformatf("basic_op%0d", ops[c-NS]), C_o, expv[c-NS]);
            end else begin
                check("basic_latency", hv_t'(out_valid_o), hv_t'(0));
            end
        end

        // Permutation corner cases.
        send_expect("rotr_1",  hv_t'(1), 3, 1,  hv_t'(1) << 511);
        send_expect("rotl_31", hv_t'(1), 4, 31, hv_t'(1) << 31);
        send_expect("rotr_0",  hv_t'(1), 3, 0,  hv_t'(1));
        send_expect("rotl_0",  hv_t'(1), 4, 0,  hv_t'(1));
        @(negedge clk_i);

        // Backpressure: fill with tags while the consumer stalls, then release.
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            step(acc < 6, hv_t'(acc + 1), '0, 6, 0, 1'b0, 1'b0);
            if (last_acc) acc++;
        end
        check("bp_accepted", hv_t'(acc), hv_t'(NS));
        check("bp_ready_low", hv_t'(last_rdy), hv_t'(0));
        check("bp_head", last_c, hv_t'(1));
        n_pops = 0;
        for (int c = 0; c < 40 && (acc < 6 || exp_q.size() != 0); c++) begin
            step(acc < 6, hv_t'(acc + 1), '0, 6, 0, 1'b1, 1'b0);
            if (last_acc) acc++;
        end
        check("bp_all_out", hv_t'(n_pops), hv_t'(6));

        // Alternating backpressure with random operands and opcodes.
        sent = 0;
        for (int c = 0; c < 200 && sent < 20; c++) begin
            step(1'b1, rand_hv(), rand_hv(), int'($urandom_range(7, 0)),
                 int'($urandom_range(31, 0)), (c % 2) == 0, 1'b0);
            if (last_acc) sent++;
        end
        check("alt_sent", hv_t'(sent), hv_t'(20));
        drain("alt_drain");

        // Flush with two results in flight and a concurrent input.
        step(1'b1, hv_t'(11), '0, 6, 0, 1'b0, 1'b0);
        step(1'b1, hv_t'(12), '0, 6, 0, 1'b0, 1'b0);
        step(1'b1, hv_t'(13), '0, 6, 0, 1'b0, 1'b1);
        step(1'b0, '0, '0, 0, 0, 1'b1, 1'b0);
        check("flush_out_valid", hv_t'(last_ov), hv_t'(0));
        check("flush_busy", hv_t'(last_busy), hv_t'(0));
        for (int c = 0; c < NS + 1; c++) step(1'b0, '0, '0, 0, 0, 1'b1, 1'b0);

        // Asynchronous reset between clock edges with a result waiting.
        step(1'b1, hv_t'(21), '0, 6, 0, 1'b0, 1'b0);
        step(1'b1, hv_t'(22), '0, 6, 0, 1'b0, 1'b0);
        @(posedge clk_i);
        #3;
        check("pre_rst_valid", hv_t'(out_valid_o), hv_t'(1));
        rst_ni     = 1'b0;
        in_valid_i = 1'b0;
        #1;
        check("arst_out_valid", hv_t'(out_valid_o), hv_t'(0));
        check("arst_c", C_o, hv_t'(0));
        check("arst_busy", hv_t'(busy_o), hv_t'(0));
        exp_q.delete();
        hold_pending = 1'b0;
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        #1 check("arst_in_ready", hv_t'(in_ready_o), hv_t'(1));
        send_expect("post_rst", hv_t'(99), 6, 0, hv_t'(99));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
